// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map and FSM states.
package pll_reconfig_pkg;

    // PLL reconfiguration register addresses
    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C     = 6'd5;
    localparam logic [5:0] ADDR_K     = 6'd7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_MODE   = 3'd1,
        ST_WR_M      = 3'd2,
        ST_WR_K      = 3'd3,
        ST_WR_C0     = 3'd4,
        ST_WR_START  = 3'd5,
        ST_SETTLE    = 3'd6,
        ST_WAIT_LOCK = 3'd7
    } pll_state_e;

    // Register address written while the sequencer sits in a given write state
    function automatic logic [5:0] state_addr(input pll_state_e s);
        logic [5:0] a;
        case (s)
            ST_WR_MODE:  a = ADDR_MODE;
            ST_WR_M:     a = ADDR_M;
            ST_WR_K:     a = ADDR_K;
            ST_WR_C0:    a = ADDR_C;
            ST_WR_START: a = ADDR_START;
            default:     a = ADDR_MODE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/pll_mgmt_wr.sv
// Avalon-MM single-write master: holds a write until accepted, flags completion.
module pll_mgmt_wr (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  start_addr,
    input  logic [31:0] start_data,
    input  logic        mgmt_waitrequest,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    output logic        wr_done
);

    logic        write_q, write_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;

    // Load a new write, hold it while stalled, drop it once accepted
    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (start) begin
            write_d = 1'b1;
            addr_d  = start_addr;
            data_d  = start_data;
        end else if (write_q && !mgmt_waitrequest) begin
            write_d = 1'b0;
            addr_d  = 6'd0;
            data_d  = 32'd0;
        end else begin
            write_d = write_q;
        end
    end

    // Bus output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= 6'd0;
            data_q  <= 32'd0;
        end else begin
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign mgmt_write     = write_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;
    assign wr_done        = write_q & ~mgmt_waitrequest;

endmodule

// File: rtl/pll_reconfig_seq.sv
// Sequencer that reprograms a PLL between two parameter sets and waits for relock.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter logic [31:0] M_VAL0       = 32'h0000_0404,
    parameter logic [31:0] M_VAL1       = 32'h0000_0404,
    parameter logic [31:0] K_VAL0       = 32'h8336_2259,
    parameter logic [31:0] K_VAL1       = 32'h8336_2259,
    parameter logic [31:0] C0_VAL0      = 32'h0000_0606,
    parameter logic [31:0] C0_VAL1      = 32'h0000_0606,
    parameter int          SETTLE       = 16,
    parameter int          LOCK_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_mode,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        cur_mode
);

    localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TMO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

    pll_state_e          state_q, state_d;
    logic                target_q, target_d;
    logic                cur_mode_q, cur_mode_d;
    logic                timeout_err_q, timeout_err_d;
    logic                done_q, done_d;
    logic                pend_valid_q, pend_valid_d;
    logic                pend_mode_q, pend_mode_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    logic        mode_sel_s;
    logic        wr_start_s;
    pll_state_e  wr_state_s;
    logic [31:0] wr_data_s;
    logic        wr_done_s;

    // Next-state, pending-request and status logic
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        cur_mode_d    = cur_mode_q;
        timeout_err_d = timeout_err_q;
        done_d        = 1'b0;
        pend_valid_d  = pend_valid_q;
        pend_mode_d   = pend_mode_q;
        settle_cnt_d  = settle_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        wr_start_s    = 1'b0;
        wr_state_s    = ST_IDLE;
        mode_sel_s    = req ? req_mode : pend_mode_q;

        // A request arriving mid-sequence is parked; the newest one wins
        if (state_q != ST_IDLE && req) begin
            pend_valid_d = 1'b1;
            pend_mode_d  = req_mode;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (req || pend_valid_q) begin
                    pend_valid_d = 1'b0;
                    target_d     = mode_sel_s;
                    // Already running the target and healthy: nothing to write
                    if (mode_sel_s == cur_mode_q && !timeout_err_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_WR_MODE;
                        wr_start_s = 1'b1;
                        wr_state_s = ST_WR_MODE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_MODE, ST_WR_M, ST_WR_K, ST_WR_C0: begin
                if (wr_done_s) begin
                    state_d    = pll_state_e'(state_q + 3'd1);
                    wr_start_s = 1'b1;
                    wr_state_s = pll_state_e'(state_q + 3'd1);
                end else begin
                    state_d = state_q;
                end
            end
            ST_WR_START: begin
                if (wr_done_s) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = {SETTLE_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_W'(SETTLE - 1)) begin
                    state_d   = ST_WAIT_LOCK;
                    tmo_cnt_d = {TMO_W{1'b0}};
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (pll_locked) begin
                    state_d       = ST_IDLE;
                    cur_mode_d    = target_q;
                    timeout_err_d = 1'b0;
                    done_d        = 1'b1;
                end else if (tmo_cnt_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end else begin
                    tmo_cnt_d = tmo_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write data for the next write state, taken from the latched target's set
    always_comb begin
        case (wr_state_s)
            ST_WR_M:  wr_data_s = target_q ? M_VAL1  : M_VAL0;
            ST_WR_K:  wr_data_s = target_q ? K_VAL1  : K_VAL0;
            ST_WR_C0: wr_data_s = target_q ? C0_VAL1 : C0_VAL0;
            default:  wr_data_s = 32'd0;
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            target_q      <= 1'b0;
            cur_mode_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            done_q        <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_mode_q   <= 1'b0;
            settle_cnt_q  <= {SETTLE_W{1'b0}};
            tmo_cnt_q     <= {TMO_W{1'b0}};
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            cur_mode_q    <= cur_mode_d;
            timeout_err_q <= timeout_err_d;
            done_q        <= done_d;
            pend_valid_q  <= pend_valid_d;
            pend_mode_q   <= pend_mode_d;
            settle_cnt_q  <= settle_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    pll_mgmt_wr u_wr (
        .clk              (clk),
        .reset            (reset),
        .start            (wr_start_s),
        .start_addr       (state_addr(wr_state_s)),
        .start_data       (wr_data_s),
        .mgmt_waitrequest (mgmt_waitrequest),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .wr_done          (wr_done_s)
    );

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign cur_mode    = cur_mode_q;

endmodule

// File: doc/pll_reconfig_seq.md
PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 SHALL have parameters, one per line:
- M_VAL0 / M_VAL1, 32'h0000_0404, M-counter word for mode 0/1.
- K_VAL0 / K_VAL1, 32'h8336_2259, fractional-K word for mode 0/1.
- C0_VAL0 / C0_VAL1, 32'h0000_0606, C0-counter word for mode 0/1.
- SETTLE, 16, cycles during which `locked` is ignored after start.
- LOCK_TIMEOUT, 1_000_000, maximum cycles waiting for lock.

REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all logic is synchronous to it.
- reset  in  1  reset; synchronous, active-high.
- req  in  1  pulse requesting a switch to `req_mode`.
- req_mode  in  1  target configuration, 0 or 1.
- mgmt_address  out  6  PLL reconfig register address.
- mgmt_write  out  1  Avalon write strobe.
- mgmt_writedata  out  32  write data.
- mgmt_waitrequest  in  1  Avalon stall.
- pll_locked  in  1  PLL lock status.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on success.
- timeout_err  out  1  sticky lock-timeout flag.
- cur_mode  out  1  last successfully applied mode.

Function
REQ-003 SHALL sample `req` only in IDLE, or latch it as pending when busy (single-deep, latest `req_mode` wins).
REQ-004 SHALL, for a request with `req_mode` == `cur_mode` and `timeout_err` = 0, issue no bus writes and pulse `done` on the next cycle.
REQ-005 SHALL otherwise step through the states:
- IDLE
- WR_MODE: addr 0, data 0 (waitrequest mode)
- WR_M: addr 4
- WR_K: addr 7
- WR_C0: addr 5
- WR_START: addr 2, data 0
- SETTLE
- WAIT_LOCK
- back to IDLE.

REQ-006 SHALL select the data for WR_M, WR_K and WR_C0 from the parameter set of the latched target mode.
REQ-007 SHALL hold `mgmt_write`, `mgmt_address` and `mgmt_writedata` stable while `mgmt_waitrequest` = 1.
REQ-008 SHALL complete a write in the first cycle where `mgmt_write` = 1 and `mgmt_waitrequest` = 0, and advance state on the following edge.
REQ-009 SHALL insert no idle cycle between consecutive writes, giving a minimum of 5 cycles of `mgmt_write` high with zero waitrequest.
REQ-010 SHALL count SETTLE cycles in the SETTLE state ignoring `pll_locked`, then enter WAIT_LOCK.
REQ-011 On `pll_locked` = 1 in WAIT_LOCK, SHALL:
- update `cur_mode` to the target mode;
- clear `timeout_err`;
- pulse `done` for 1 cycle;
- return to IDLE.

REQ-012 SHALL, if WAIT_LOCK lasts LOCK_TIMEOUT cycles without lock:
- set `timeout_err`;
- leave `cur_mode` unchanged;
- issue no `done`;
- return to IDLE.

REQ-013 SHALL keep `timeout_err` asserted until the next successful lock or reset; a new request while `timeout_err` = 1 always runs the full sequence.
REQ-014 SHALL, on return to IDLE with a pending request, start it in the next cycle (IDLE for exactly 1 cycle).
REQ-015 SHALL treat `req` asserted in the same cycle that `done` pulses as pending, not lost.
REQ-016 SHALL assert `busy` in every state except IDLE, combinationally from state.
REQ-017 SHALL size the timeout counter as $clog2(LOCK_TIMEOUT+1) bits, saturating, cleared on entry to WAIT_LOCK.

Reset
REQ-018 SHALL, while `reset` = 1 at a clk edge, drive the following regardless of state, including mid-write with waitrequest high:
- state = IDLE
- `mgmt_write` = 0, `mgmt_address` = 0, `mgmt_writedata` = 0
- `busy` = 0, `done` = 0, `timeout_err` = 0
- `cur_mode` = 0
- pending cleared.

REQ-019 SHALL treat the post-reset PLL as running mode 0 (its compiled default) without issuing writes.

Structure
REQ-020 SHALL place in shared package `pll_reconfig_pkg`:
- register address constants MODE = 0, START = 2, M = 4, C = 5, K = 7;
- the state enumeration.

REQ-021 SHALL place the Avalon single-write handshake (hold until not waitrequest, completion pulse) in sub-module `pll_mgmt_wr`.

Verification
REQ-022 SHALL cover: after reset, req = 1 with mode 1 and waitrequest = 0 -> writes (0,0), (4,M_VAL1), (7,K_VAL1), (5,C0_VAL1), (2,0) on 5 consecutive cycles; lock asserted after 20 cycles -> done pulse, cur_mode = 1.
REQ-023 SHALL cover: waitrequest held high 3 cycles during WR_K -> address 7 and data stable for 4 cycles of `mgmt_write`, sequence otherwise unchanged.
REQ-024 SHALL cover: LOCK_TIMEOUT = 100, locked held 0 -> timeout_err = 1 exactly 100 cycles after WAIT_LOCK entry, cur_mode unchanged, no done.
REQ-025 SHALL cover: req mode 0 while idle with cur_mode = 0 -> no mgmt_write, done 1 cycle later.
REQ-026 SHALL cover: req mode 1 then mode 0 during busy -> mode 0 sequence starts 1 cycle after the first done; final cur_mode = 0.
REQ-027 SHALL cover: reset asserted during WR_M with waitrequest = 1 -> next cycle mgmt_write = 0, busy = 0, cur_mode = 0.
